vga_draw_arbiter: RTL and testbench

- Shares the single pixel-write port of vga_adapter (color, x, y, write) among NREQ game drawing clients, e.g. ship, enemies, projectiles, erase.
- Each client requests a solid rectangle fill. The block grants clients round-robin, then streams the rectangle one pixel per clock into the adapter.
- Pixels outside the screen are clipped.
- Sits between game logic and vga_adapter, whose background MIF stays underneath.

---
 rtl/vga_draw_arbiter_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/vga_draw_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared types and default geometry for the VGA draw arbiter (640x480, 9-bit color).
package vga_draw_arbiter_pkg;

    localparam int unsigned NREQ_DEF        = 4;
    localparam int unsigned NX_DEF          = 10;
    localparam int unsigned NY_DEF          = 9;
    localparam int unsigned XMAX_DEF        = 640;
    localparam int unsigned YMAX_DEF        = 480;
    localparam int unsigned COLOR_DEPTH_DEF = 9;
    localparam int unsigned WB_DEF          = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDraw   = 2'd1,
        StFinish = 2'd2
    } state_t;

    // Width of a client index; at least one bit so a single client still has a port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            valid
);

    int unsigned j;

    // Scan clients starting at the pointer; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Grants drawing clients round-robin and streams each solid rectangle, one pixel
// per clock, into the vga_adapter write port with off-screen pixels clipped.
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int unsigned NREQ        = NREQ_DEF,
    parameter int unsigned nX          = NX_DEF,
    parameter int unsigned nY          = NY_DEF,
    parameter int unsigned XMAX        = XMAX_DEF,
    parameter int unsigned YMAX        = YMAX_DEF,
    parameter int unsigned COLOR_DEPTH = COLOR_DEPTH_DEF,
    parameter int unsigned WB          = WB_DEF
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*nX-1:0]            req_x0,
    input  logic [NREQ*nY-1:0]            req_y0,
    input  logic [NREQ*WB-1:0]            req_w,
    input  logic [NREQ*WB-1:0]            req_h,
    input  logic [NREQ*COLOR_DEPTH-1:0]   req_color,
    input  logic                          frame_hold,
    output logic [NREQ-1:0]               ack,
    output logic [NREQ-1:0]               done,
    output logic                          busy,
    output logic [nX-1:0]                 vga_x,
    output logic [nY-1:0]                 vga_y,
    output logic [COLOR_DEPTH-1:0]        vga_color,
    output logic                          vga_write
);

    localparam int unsigned IW = idx_width(NREQ);

    state_t                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          gnt_q, gnt_d;
    logic [nX-1:0]          x0_q, x0_d;
    logic [nY-1:0]          y0_q, y0_d;
    logic [WB-1:0]          w_q, w_d, h_q, h_d;
    logic [COLOR_DEPTH-1:0] color_q, color_d;
    // col/row point at the next pixel to emit; all_q marks the last one as emitted.
    logic [WB-1:0]          col_q, col_d, row_q, row_d;
    logic                   all_q, all_d;
    logic [NREQ-1:0]        ack_q, ack_d, done_q, done_d;
    logic                   busy_q, busy_d;
    logic [nX-1:0]          vga_x_q, vga_x_d;
    logic [nY-1:0]          vga_y_q, vga_y_d;
    logic [COLOR_DEPTH-1:0] vga_color_q, vga_color_d;
    logic                   vga_write_q, vga_write_d;

    logic [NREQ-1:0]        arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_valid;

    logic [nX-1:0]          rx0;
    logic [nY-1:0]          ry0;
    logic [WB-1:0]          rw, rh;
    logic [COLOR_DEPTH-1:0] rcolor;

    logic                   emit;
    logic [nX-1:0]          ex0;
    logic [nY-1:0]          ey0;
    logic [WB-1:0]          ecol, erow;
    logic [COLOR_DEPTH-1:0] ecolor;
    logic [nX:0]            sum_x;
    logic [nY:0]            sum_y;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // Operands of the client the arbiter currently picks.
    always_comb begin
        rx0    = req_x0[arb_idx*nX +: nX];
        ry0    = req_y0[arb_idx*nY +: nY];
        rw     = req_w[arb_idx*WB +: WB];
        rh     = req_h[arb_idx*WB +: WB];
        rcolor = req_color[arb_idx*COLOR_DEPTH +: COLOR_DEPTH];
    end

    // Next-state, operand latching, pixel sequencing and registered output values.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        w_d         = w_q;
        h_d         = h_q;
        color_d     = color_q;
        col_d       = col_q;
        row_d       = row_q;
        all_d       = all_q;
        ack_d       = '0;
        done_d      = '0;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        vga_write_d = 1'b0;
        emit        = 1'b0;
        ex0         = x0_q;
        ey0         = y0_q;
        ecol        = col_q;
        erow        = row_q;
        ecolor      = color_q;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    gnt_d   = arb_idx;
                    ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    x0_d    = rx0;
                    y0_d    = ry0;
                    w_d     = rw;
                    h_d     = rh;
                    color_d = rcolor;
                    ack_d   = arb_grant;
                    if (rw == '0 || rh == '0) begin
                        state_d = StFinish;
                        done_d  = arb_grant;
                    end else begin
                        // First pixel goes out in the same cycle as ack.
                        state_d = StDraw;
                        emit    = 1'b1;
                        ex0     = rx0;
                        ey0     = ry0;
                        ecol    = '0;
                        erow    = '0;
                        ecolor  = rcolor;
                        all_d   = (rw == WB'(1)) && (rh == WB'(1));
                        col_d   = (rw == WB'(1)) ? WB'(0) : WB'(1);
                        row_d   = (rw == WB'(1)) ? WB'(1) : WB'(0);
                    end
                end
            end
            StDraw: begin
                if (all_q) begin
                    state_d = StFinish;
                    done_d  = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
                end else if (!frame_hold) begin
                    emit  = 1'b1;
                    all_d = (col_q == w_q - WB'(1)) && (row_q == h_q - WB'(1));
                    if (col_q == w_q - WB'(1)) begin
                        col_d = '0;
                        row_d = row_q + WB'(1);
                    end else begin
                        col_d = col_q + WB'(1);
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Sums are one bit wider than the coordinate so off-screen never wraps on-screen.
        sum_x = {1'b0, ex0} + {{(nX + 1 - WB){1'b0}}, ecol};
        sum_y = {1'b0, ey0} + {{(nY + 1 - WB){1'b0}}, erow};
        if (emit) begin
            vga_x_d     = sum_x[nX-1:0];
            vga_y_d     = sum_y[nY-1:0];
            vga_color_d = ecolor;
            vga_write_d = (sum_x < (nX + 1)'(XMAX)) && (sum_y < (nY + 1)'(YMAX));
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset abandons any rectangle in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gnt_q       <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            all_q       <= 1'b0;
            ack_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            w_q         <= w_d;
            h_q         <= h_d;
            color_q     <= color_d;
            col_q       <= col_d;
            row_q       <= row_d;
            all_q       <= all_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            vga_write_q <= vga_write_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;
    assign vga_write = vga_write_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed self-checking bench for vga_draw_arbiter with hand-computed expectations.
module tb_vga_draw_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [39:0] req_x0 = '0;
    logic [35:0] req_y0 = '0;
    logic [23:0] req_w = '0;
    logic [23:0] req_h = '0;
    logic [35:0] req_color = '0;
    logic        frame_hold = 1'b0;
    logic [3:0]  ack, done;
    logic        busy;
    logic [9:0]  vga_x;
    logic [8:0]  vga_y;
    logic [8:0]  vga_color;
    logic        vga_write;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int k;

    int wr_x[$], wr_y[$], wr_c[$], wr_cyc[$];
    int ack_id[$], ack_cyc[$], done_id[$], done_cyc[$];
    int busy_cnt = 0;

    vga_draw_arbiter u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_color  (req_color),
        .frame_hold (frame_hold),
        .ack        (ack),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_color  (vga_color),
        .vga_write  (vga_write)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Log every write, ack and done on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (vga_write) begin
            wr_x.push_back(int'(vga_x));
            wr_y.push_back(int'(vga_y));
            wr_c.push_back(int'(vga_color));
            wr_cyc.push_back(cyc);
        end
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                ack_id.push_back(i);
                ack_cyc.push_back(cyc);
            end
            if (done[i]) begin
                done_id.push_back(i);
                done_cyc.push_back(cyc);
            end
        end
        if (busy) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        wr_x.delete(); wr_y.delete(); wr_c.delete(); wr_cyc.delete();
        ack_id.delete(); ack_cyc.delete(); done_id.delete(); done_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic set_client(input int i, input int x0, input int y0, input int w,
                              input int h, input int c);
        req_x0[i*10 +: 10]  = x0[9:0];
        req_y0[i*9 +: 9]    = y0[8:0];
        req_w[i*6 +: 6]     = w[5:0];
        req_h[i*6 +: 6]     = h[5:0];
        req_color[i*9 +: 9] = c[8:0];
    endtask

    // Step until a done pulse (bounded), optionally dropping each req once acked.
    task automatic run_until_done(input int max_cyc, input bit drop, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            if (drop) req = req & ~ack;
            n++;
        end while (done == '0 && n < max_cyc);
        check(tag, int'(done != '0), 1);
        tick();
    endtask

    initial begin
        // Reset state.
        #3;
        check("rst_ack", int'(ack), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_write", int'(vga_write), 0);
        check("rst_xy", int'(vga_x) + int'(vga_y) + int'(vga_color), 0);
        tick();
        #2 resetn = 1'b1;
        tick();

        // Basic 3x2 rectangle on client 0.
        clear_logs();
        set_client(0, 10, 20, 3, 2, 9'h1C0);
        req = 4'b0001;
        k = cyc;
        run_until_done(40, 1'b1, "t1_timeout");
        check("t1_ack_n", ack_id.size(), 1);
        check("t1_ack_id", ack_id[0], 0);
        check("t1_ack_cyc", ack_cyc[0], k + 1);
        check("t1_wr_n", wr_x.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_x%0d", i), wr_x[i], 10 + (i % 3));
            check($sformatf("t1_y%0d", i), wr_y[i], 20 + (i / 3));
            check($sformatf("t1_cyc%0d", i), wr_cyc[i], k + 1 + i);
        end
        check("t1_color", wr_c[0], 9'h1C0);
        check("t1_done_id", done_id[0], 0);
        check("t1_done_cyc", done_cyc[0], k + 7);
        tick();
        check("t1_idle_busy", int'(busy), 0);

        // Rotation with all four clients holding 1x1 requests from pointer 0.
        #2 resetn = 1'b0;
        tick();
        #2 resetn = 1'b1;
        tick();
        clear_logs();
        for (int i = 0; i < 4; i++) set_client(i, 100 + i, 30, 1, 1, i + 1);
        req = 4'b1111;
        for (int n = 0; n < 40 && ack_id.size() < 5; n++) tick();
        req = '0;
        repeat (4) tick();
        check("t2_ack_n", ack_id.size(), 5);
        check("t2_wr_n", wr_x.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_ack%0d", i), ack_id[i], i % 4);
            check($sformatf("t2_wx%0d", i), wr_x[i], 100 + (i % 4));
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_gap%0d", i), ack_cyc[i+1] - ack_cyc[i], 3);

        // Clipping at the bottom-right corner.
        clear_logs();
        set_client(3, 638, 479, 4, 2, 9'h0FF);
        req = 4'b1000;
        k = cyc;
        run_until_done(40, 1'b1, "t3_timeout");
        check("t3_wr_n", wr_x.size(), 2);
        check("t3_x0", wr_x[0], 638);
        check("t3_x1", wr_x[1], 639);
        check("t3_y1", wr_y[1], 479);
        check("t3_wcyc1", wr_cyc[1], k + 2);
        check("t3_done_cyc", done_cyc[0], k + 9);
        check("t3_busy_cnt", busy_cnt, 9);

        // Zero-width request on client 2.
        clear_logs();
        set_client(2, 50, 50, 0, 5, 9'h011);
        req = 4'b0100;
        k = cyc;
        run_until_done(10, 1'b1, "t4_timeout");
        check("t4_ack_id", ack_id[0], 2);
        check("t4_ack_cyc", ack_cyc[0], k + 1);
        check("t4_done_id", done_id[0], 2);
        check("t4_done_cyc", done_cyc[0], k + 1);
        check("t4_wr_n", wr_x.size(), 0);
        check("t4_busy_cnt", busy_cnt, 1);

        // frame_hold for three cycles just before pixel 2 of a 4x1 rectangle.
        clear_logs();
        set_client(1, 200, 50, 4, 1, 9'h155);
        req = 4'b0010;
        k = cyc;
        tick();
        req = '0;
        tick();
        frame_hold = 1'b1;
        repeat (3) tick();
        frame_hold = 1'b0;
        run_until_done(20, 1'b1, "t5_timeout");
        check("t5_wr_n", wr_x.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t5_x%0d", i), wr_x[i], 200 + i);
        check("t5_p2_cyc", wr_cyc[2], k + 6);
        check("t5_done_cyc", done_cyc[0], k + 8);

        // Reset in the middle of a draw: pointer returns to 0, so client 1 beats client 3.
        clear_logs();
        set_client(1, 0, 0, 10, 10, 9'h005);
        req = 4'b0010;
        tick();
        req = '0;
        set_client(1, 300, 100, 1, 1, 9'h007);
        set_client(3, 400, 100, 1, 1, 9'h003);
        req = 4'b1010;
        repeat (3) tick();
        check("t6_busy_pre", int'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_write", int'(vga_write), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_x", int'(vga_x), 0);
        clear_logs();
        tick();
        tick();
        #2 resetn = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                tick();
                n++;
            end while (ack == '0 && n < 10);
            check("t6_grant", int'(ack), 4'b0010);
        end
        req = '0;
        run_until_done(10, 1'b0, "t6_timeout");
        check("t6_done_n", done_id.size(), 1);
        check("t6_done_id", done_id[0], 1);
        check("t6_wr_n", wr_x.size(), 1);
        check("t6_wr_x", wr_x[0], 300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
